// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_pkg
//  Description : Shared constants for the FSM block set: control-state
//                encoding and parameter width limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package fsm_pkg;

  // Control FSM state encoding (explicit 1-bit width)
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Legal parameter ceilings for the pattern detector family
  localparam int SEQ_LEN_MAX = 32;
  localparam int CNT_W_MAX   = 16;

  // True when a detector configuration lies inside its supported range
  function automatic bit cfg_legal(input int seq_len, input int cnt_w);
    return (seq_len >= 2) && (seq_len <= SEQ_LEN_MAX) &&
           (cnt_w >= 1) && (cnt_w <= CNT_W_MAX);
  endfunction

endpackage : fsm_pkg
`default_nettype wire

// File: rtl/seq_history.sv
`default_nettype none
// ============================================================================
//  Module      : seq_history
//  Description : Serial history shift register with a saturating fill
//                counter. Presents the look-ahead history (including the bit
//                being shifted in) and whether that history is fully populated.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_history
  import fsm_pkg::*;
#(
  parameter int SEQ_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               fill_rst,
  input  logic               x,
  output logic [SEQ_LEN-1:0] hist_n,
  output logic               full_n
);

  localparam int                FILL_W   = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);

  logic [SEQ_LEN-1:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_n;

  // Look-ahead view: history and fill level as they would be after this shift
  always_comb begin
    hist_n = {hist[SEQ_LEN-2:0], x};
    fill_n = (fill == FILL_MAX) ? FILL_MAX : (fill + 1'b1);
    full_n = (fill_n == FILL_MAX);
  end

  // History/fill registers: clear wins, otherwise advance only on a shift.
  // A non-overlapping match empties the fill level so the next match must be
  // built entirely from fresh bits; the stale history bits are then harmless
  // because they are pushed out before the fill level reaches full again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_n;
      fill <= fill_rst ? '0 : fill_n;
    end
  end

endmodule : seq_history
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Parametrised serial bit-pattern detector. Compares the last
//                SEQ_LEN qualified bits against a runtime-loaded pattern, with
//                overlapping / non-overlapping modes, a registered one-cycle
//                match pulse and a saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param
  import fsm_pkg::*;
#(
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               in_valid,
  input  logic               load,
  input  logic [SEQ_LEN-1:0] pattern,
  input  logic               ovl_mode,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Elaboration-time view of the configuration range; an out-of-range build
  // is caught by the generate guard below.
  localparam bit CFG_OK = cfg_legal(SEQ_LEN, CNT_W);

  logic [0:0]         state;
  logic [0:0]         state_n;
  logic               run;
  logic               shift_en;
  logic               match;
  logic               fill_rst;
  logic [SEQ_LEN-1:0] pattern_q;
  logic               mode_q;
  logic [SEQ_LEN-1:0] hist_n;
  logic               full_n;

  // Refuse to elaborate an unsupported configuration
  if (!CFG_OK) begin : g_cfg_bad
    illegal_seq_detect_param_configuration u_cfg_bad ();
  end

  // Control FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Control FSM next state: load arms the block, only rst disarms it
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (load) state_n = ST_RUN;
      ST_RUN:  state_n = ST_RUN;
      default: state_n = ST_IDLE;
    endcase
  end

  // Control FSM outputs: load has priority over sampling on the same cycle
  always_comb begin
    run      = (state == ST_RUN);
    shift_en = run && in_valid && !load;
  end

  // Configuration latched only on the load strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= '0;
      mode_q    <= 1'b0;
    end else if (load) begin
      pattern_q <= pattern;
      mode_q    <= ovl_mode;
    end
  end

  // Shift register and fill tracking
  seq_history #(
    .SEQ_LEN (SEQ_LEN)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .clear    (load),
    .shift_en (shift_en),
    .fill_rst (fill_rst),
    .x        (x),
    .hist_n   (hist_n),
    .full_n   (full_n)
  );

  // Match decision on the history as it will be after this bit is taken
  always_comb begin
    match    = shift_en && full_n && (hist_n == pattern_q);
    fill_rst = match && !mode_q;
  end

  // Registered match pulse, cleared by load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= 1'b0;
    end else if (load) begin
      y <= 1'b0;
    end else begin
      y <= match;
    end
  end

  // Saturating match counter, restarted by load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (load) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

  assign armed = run;

endmodule : seq_detect_param
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Directed self-checking bench for seq_detect_param. A queue
//                based reference model predicts y / match_cnt / armed every
//                cycle; literal expectations pin the scenario outcomes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         x;
  logic         in_valid;
  logic         load;
  logic [L-1:0] pattern;
  logic         ovl_mode;
  logic         y_a, y_b;
  logic [7:0]   cnt_a;
  logic [1:0]   cnt_b;
  logic         armed_a, armed_b;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  bit           m_armed;
  bit           m_q[$];
  logic [L-1:0] m_pat;
  bit           m_ovl;
  bit           m_y;
  int           m_cnt8;
  int           m_cnt2;
  int           y_pulses;

  always #5 clk = ~clk;

  seq_detect_param #(.SEQ_LEN(L), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .load(load),
    .pattern(pattern), .ovl_mode(ovl_mode),
    .y(y_a), .match_cnt(cnt_a), .armed(armed_a)
  );

  seq_detect_param #(.SEQ_LEN(L), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .load(load),
    .pattern(pattern), .ovl_mode(ovl_mode),
    .y(y_b), .match_cnt(cnt_b), .armed(armed_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_q.delete(); m_pat = '0; m_ovl = 0; m_y = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  // One sampling edge worth of the specification's rules
  task automatic model_edge(input bit l, input bit xb, input bit v,
                            input logic [L-1:0] p, input bit o);
    logic [L-1:0] w;
    bit           hit;
    if (l) begin
      m_armed = 1; m_pat = p; m_ovl = o; m_q.delete(); m_y = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (m_armed && v) begin
      m_q.push_back(xb);
      if (m_q.size() > L) void'(m_q.pop_front());
      hit = 0;
      if (m_q.size() == L) begin
        w = '0;
        foreach (m_q[i]) w = {w[L-2:0], m_q[i]};
        hit = (w == m_pat);
      end
      m_y = hit;
      if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
        if (!m_ovl) m_q.delete();
      end
    end else begin
      m_y = 0;
    end
  endtask

  // Drive one cycle, advance the model on the edge, compare just after it
  task automatic step(input bit l, input bit xb, input bit v,
                      input logic [L-1:0] p, input bit o);
    load = l; x = xb; in_valid = v; pattern = p; ovl_mode = o;
    @(posedge clk);
    model_edge(l, xb, v, p, o);
    #1;
    chk("y",         {31'd0, y_a},     {31'd0, m_y});
    chk("y_sat",     {31'd0, y_b},     {31'd0, m_y});
    chk("match_cnt", {24'd0, cnt_a},   m_cnt8);
    chk("cnt_sat",   {30'd0, cnt_b},   m_cnt2);
    chk("armed",     {31'd0, armed_a}, {31'd0, m_armed});
    chk("armed_sat", {31'd0, armed_b}, {31'd0, m_armed});
    if (y_a) y_pulses++;
  endtask

  task automatic load_pat(input logic [L-1:0] p, input bit o);
    step(1'b1, 1'b0, 1'b0, p, o);
  endtask

  task automatic bit_in(input bit b);
    step(1'b0, b, 1'b1, 4'b0000, 1'b0);
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 4'b1111, 1'b1);
  endtask

  logic [6:0] stream7;
  logic [7:0] ybits;
  logic [1:0] sat_trace [8];

  initial begin
    stream7 = 7'b1011011;
    rst = 1'b1; x = 0; in_valid = 0; load = 0; pattern = '0; ovl_mode = 0;
    model_reset();
    y_pulses = 0;
    #12;
    chk("rst_y",     {31'd0, y_a},     0);
    chk("rst_cnt",   {24'd0, cnt_a},   0);
    chk("rst_armed", {31'd0, armed_a}, 0);
    rst = 1'b0;

    // IDLE: matching stream before any load is ignored
    for (int i = 0; i < 4; i++) step(1'b0, stream7[6-i], 1'b1, 4'b1011, 1'b1);
    chk("idle_pulses", y_pulses, 0);
    chk("idle_armed",  {31'd0, armed_a}, 0);

    // Overlap mode: 1011 in 1,0,1,1,0,1,1
    load_pat(4'b1011, 1'b1);
    y_pulses = 0;
    for (int i = 0; i < 7; i++) begin
      bit_in(stream7[6-i]);
      ybits[i] = y_a;
    end
    chk("ovl_y_bit4",  {31'd0, ybits[3]}, 1);
    chk("ovl_y_bit7",  {31'd0, ybits[6]}, 1);
    chk("ovl_pulses",  y_pulses, 2);
    chk("ovl_cnt",     {24'd0, cnt_a}, 2);

    // Non-overlap mode: same stream
    load_pat(4'b1011, 1'b0);
    chk("reload_cnt", {24'd0, cnt_a}, 0);
    y_pulses = 0;
    for (int i = 0; i < 7; i++) bit_in(stream7[6-i]);
    chk("novl_pulses", y_pulses, 1);
    chk("novl_cnt",    {24'd0, cnt_a}, 1);

    // Bubbles between valid bits
    load_pat(4'b1011, 1'b1);
    y_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      bit_in(stream7[6-i]);
      if (i == 3) chk("bub_y_after4", {31'd0, y_a}, 1);
      bubble(3);
    end
    chk("bub_pulses", y_pulses, 1);
    chk("bub_cnt",    {24'd0, cnt_a}, 1);

    // Saturation on the 2-bit counter instance
    load_pat(4'b1111, 1'b1);
    y_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      bit_in(1'b1);
      sat_trace[i] = cnt_b;
    end
    chk("sat_pulses", y_pulses, 5);
    chk("sat_c4", {30'd0, sat_trace[3]}, 1);
    chk("sat_c5", {30'd0, sat_trace[4]}, 2);
    chk("sat_c6", {30'd0, sat_trace[5]}, 3);
    chk("sat_c8", {30'd0, sat_trace[7]}, 3);
    chk("sat_wide_cnt", {24'd0, cnt_a}, 5);
    bit_in(1'b0);

    // Async reset mid-sequence with a nonzero count
    load_pat(4'b1011, 1'b1);
    for (int i = 0; i < 4; i++) bit_in(stream7[6-i]);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    chk("pre_rst_cnt", {24'd0, cnt_a}, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_y",     {31'd0, y_a},     0);
    chk("arst_cnt",   {24'd0, cnt_a},   0);
    chk("arst_armed", {31'd0, armed_a}, 0);
    model_reset();
    #1 rst = 1'b0;
    y_pulses = 0;
    for (int i = 0; i < 4; i++) step(1'b0, stream7[6-i], 1'b1, 4'b1011, 1'b1);
    chk("post_rst_pulses", y_pulses, 0);

    // Reload priority: load with a valid bit discards that bit
    load_pat(4'b1011, 1'b1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1);
    chk("reload_cnt0", {24'd0, cnt_a}, 0);
    y_pulses = 0;
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    chk("reload_pulses", y_pulses, 1);
    chk("reload_cnt1",   {24'd0, cnt_a}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_seq_detect_param
`default_nettype wire

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector, the successor to the fixed 4-bit "1011" detector in the FSM block set. It samples one qualified bit per clock and compares the last SEQ_LEN bits against a runtime-loaded pattern. It supports overlapping and non-overlapping match modes and accumulates a saturating match count. It sits between the serial input front-end and the status/interrupt logic.

## Interface
- SEQ_LEN, 4: pattern length in bits; legal range 2..32.
- CNT_W, 8: width of the match counter; legal range 1..16.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- x  in  1  serial data bit.
- in_valid  in  1  x is sampled only on cycles where this is 1.
- load  in  1  one-cycle strobe; latches pattern and ovl_mode, clears history and counter.
- pattern  in  SEQ_LEN  target sequence, MSB first; pattern[SEQ_LEN-1] is the oldest bit of the sequence.
- ovl_mode  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- y  out  1  registered one-cycle match pulse.
- match_cnt  out  CNT_W  saturating count of matches since the last load or reset.
- armed  out  1  high once a pattern has been loaded.

## Operation
- **States:**
  - IDLE after reset. The detector does not match, y stays 0, and in_valid is ignored.
  - IDLE to RUN on load.
  - RUN stays in RUN; a further load re-initialises it in place.
  - Only rst returns the block to IDLE.
- **Internal registers:**
  - pattern_q (SEQ_LEN bits)
  - mode_q (1 bit)
  - hist (SEQ_LEN bits; newest bit in bit 0)
  - fill (counts 0..SEQ_LEN; saturates at SEQ_LEN)
- **load cycle, in any state:**
  - pattern_q <= pattern, mode_q <= ovl_mode.
  - hist, fill and match_cnt are cleared, and y <= 0.
  - x on that cycle is discarded even if in_valid=1; load has priority.
- **RUN with in_valid=1 and load=0:**
  - hist_n = {hist[SEQ_LEN-2:0], x}.
  - fill_n = min(fill+1, SEQ_LEN).
  - match = (fill_n == SEQ_LEN) && (hist_n == pattern_q).
- **On match:**
  - y <= 1.
  - match_cnt <= match_cnt+1, holding at 2^CNT_W-1 once saturated.
  - If mode_q=0, fill <= 0: the next match needs SEQ_LEN fresh bits.
  - If mode_q=1, fill stays SEQ_LEN, so a suffix of the match may start the next one.
- **No match, or in_valid=0:**
  - y <= 0.
  - With in_valid=0, hist, fill and match_cnt are held. A bubble does not break a sequence.
- Pattern changes take effect only on load; pattern and ovl_mode are ignored at all other times.

## Timing
- **Reset values:** y=0, match_cnt=0, armed=0, state IDLE, hist=0, fill=0, pattern_q=0, mode_q=0.
- **Reset assertion:** asynchronous, so outputs clear without waiting for a clock edge.
- **Reset deassertion:** the first sampling edge is the first rising clk after rst falls.
- **Latency:** y rises in the cycle after the edge that samples the final pattern bit, and lasts exactly one cycle. match_cnt updates on the same edge as y.
- **Back-to-back matches** (overlap mode with a periodic pattern such as all-ones): y may stay high on consecutive cycles, with one count per cycle.
- **armed** rises on the edge that samples load=1.
- **rst mid-sequence:** partial history is lost; the block returns to IDLE and must be reloaded.
- **load mid-sequence:** partial history is lost, and the count restarts at 0 on the following cycle.
- **Saturation:** match_cnt holds at its maximum value; y still pulses on each match.

## Structure
- **Shared package fsm_pkg:**
  - State encoding constants ST_IDLE=1'b0 and ST_RUN=1'b1.
  - Width limits SEQ_LEN_MAX=32 and CNT_W_MAX=16.
- **Sub-module seq_history:**
  - Holds the shift register and fill counter, with parameter SEQ_LEN.
  - Inputs: shift enable, clear, and fill-reset-on-match.
  - Outputs: hist_n and full_n.
- **Top level:** owns the control FSM, match compare, y register and counter.

## Test plan
1. **Overlap mode:** SEQ_LEN=4, load pattern 4'b1011 with ovl_mode=1, stream 1,0,1,1,0,1,1 (valid every cycle). Required: y pulses after the 4th and 7th bits, match_cnt=2.
2. **Non-overlap mode:** same stream with ovl_mode=0. Required: y pulses only after the 4th bit, match_cnt=1.
3. **Bubbles:** stream 1,0,1,1 with in_valid=0 for 3 cycles between each bit. Required: a single y pulse one cycle after the valid 4th bit, match_cnt=1.
4. **Saturation:** CNT_W=2, pattern 4'b1111, ovl_mode=1, eight 1s. Required: y high for 5 consecutive cycles, match_cnt counts 1,2,3 then holds at 3.
5. **IDLE and async reset:**
   - Before any load, stream 1,0,1,1 with pattern input 4'b1011. Required: y=0, armed=0.
   - Then load, send 1,0,1, and assert rst asynchronously mid-cycle. Required: outputs clear immediately, armed=0.
6. **Reload priority:** load pattern 1011, send 1,0,1, then pulse load with x=1, in_valid=1 and new pattern 4'b0110. Required: that bit is discarded, match_cnt=0; stream 0,1,1,0 gives exactly one y pulse.
